// File: rtl/shifter_left_seq.sv
// Sequential arithmetic left shifter: one bit position per clock, valid/ready on both sides, sticky overflow.
// Optional saturation on overflow when SHIFTER_LEFT_SAT_EN is defined; otherwise results wrap.
module shifter_left_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] xin,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] xout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] data_reg;
  logic [SHW-1:0]   cnt_reg;
  logic             sign_reg;
  logic             ovf_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             shift_ovf;

  // Before the first overflow the top bit always equals the operand sign, so the
  // sign term only ever repeats an overflow the sticky flag already holds.
  assign shift_ovf = (data_reg[WIDTH-1] != data_reg[WIDTH-2]) ||
                     (data_reg[WIDTH-1] != sign_reg);

`ifdef SHIFTER_LEFT_SAT_EN
  logic [WIDTH-1:0] sat_value;
  assign sat_value = sign_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      cnt_reg       <= '0;
      sign_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg     <= xin;
            cnt_reg      <= shamt;
            sign_reg     <= xin[WIDTH-1];
            ovf_reg      <= 1'b0;
            in_ready_reg <= 1'b0;
            if (shamt == '0) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (shift_ovf) ovf_reg <= 1'b1;
`ifdef SHIFTER_LEFT_SAT_EN
          // Once saturated the word is frozen for the rest of the operation.
          if (ovf_reg) data_reg <= data_reg;
          else if (shift_ovf) data_reg <= sat_value;
          else data_reg <= {data_reg[WIDTH-2:0], 1'b0};
`else
          data_reg <= {data_reg[WIDTH-2:0], 1'b0};
`endif
          cnt_reg <= cnt_reg - SHW'(1);
          if (cnt_reg == SHW'(1)) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign xout      = data_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_shifter_left_seq.sv
// Directed self-checking bench for shifter_left_seq; expected values follow SHIFTER_LEFT_SAT_EN.
module tb_shifter_left_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] xin = '0;
  logic [3:0]  shamt = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] xout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  shifter_left_seq #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .xin(xin), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .xout(xout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Launch one word, measure accept-to-out_valid edges, check the held result.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [3:0] s,
                        input logic [15:0] ex, input logic eo);
    int edges;
    @(negedge clk);
    in_valid = 1'b1; xin = x; shamt = s;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_lat"}, edges, int'(s) + 1);
    check({tag, "_xout"}, xout, ex);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_rdy"}, in_ready, 1'b0);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vld_clr"}, out_valid, 1'b0);
    check({tag, "_rdy_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_xout", xout, 16'h0000);
    check("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 16'h0003, 4'd4, 16'h0030, 1'b0);
    take("basic");
    run_op("neg15", 16'hFFFF, 4'd15, 16'h8000, 1'b0);
    take("neg15");
    run_op("zero", 16'h1234, 4'd0, 16'h1234, 1'b0);
    take("zero");
`ifdef SHIFTER_LEFT_SAT_EN
    run_op("posovf", 16'h4000, 4'd1, 16'h7FFF, 1'b1);
    take("posovf");
    run_op("negovf", 16'hA000, 4'd3, 16'h8000, 1'b1);
    take("negovf");
`else
    run_op("posovf", 16'h4000, 4'd1, 16'h8000, 1'b1);
    take("posovf");
    run_op("negovf", 16'hA000, 4'd3, 16'h0000, 1'b1);
    take("negovf");
`endif

    // Back-pressure: result must hold and new data must be ignored.
    run_op("hold", 16'h0005, 4'd2, 16'h0014, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; xin = 16'h7777; shamt = 4'd1;
      @(posedge clk);
      @(negedge clk);
      check("hold_xout", xout, 16'h0014);
      check("hold_hs", {30'd0, in_ready, out_valid}, 32'd1);
    end
    check("hold_ovf", ovf, 1'b0);
    in_valid = 1'b0;
    take("hold");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_once", out_valid, 1'b0);
      check("hold_nocap", xout, 16'h0014);
    end

    // Asynchronous abort in the middle of a shift.
    @(negedge clk);
    in_valid = 1'b1; xin = 16'h0001; shamt = 4'd8;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_xout", xout, 16'h0000);
    check("abort_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("restart", 16'h0001, 4'd2, 16'h0004, 1'b0);
    take("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_left_seq.md
Name: shifter_left_seq

Overview:
- Sequential arithmetic left shifter: the scale-up counterpart to the team's combinational one-bit arithmetic right shifter.
- Used in the delta-sigma datapath to restore gain after right-shift attenuation, for example when re-scaling integrator or feedback words.
- Shifts a signed 16-bit word left by 0..15 positions at one position per clock.
- Reports overflow when the result no longer represents the true product.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, data word width in bits (two's complement).
- SHW, 4, width of the shift-amount field; maximum shift is 2^SHW-1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  xin and shamt are valid.
- in_ready  output  1  block can accept a new word.
- xin  input  WIDTH  signed operand.
- shamt  input  SHW  left-shift amount, 0..15.
- out_valid  output  1  xout and ovf are valid.
- out_ready  input  1  downstream accepts the result.
- xout  output  WIDTH  shifted result.
- ovf  output  1  sticky overflow flag for the current operation.

Behaviour:
- Reset:
  - Reset is asynchronous, active-low, with one clock.
  - While rst_n=0: state=IDLE, internal data register=0, counter=0, sign register=0.
  - Output values under reset: in_ready=1, out_valid=0, xout=0, ovf=0.
  - Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on a rising edge with in_valid=1: reg<=xin, cnt<=shamt, sign<=xin[WIDTH-1], ovf<=0.
  - Next state is DONE if shamt==0, otherwise SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge: if reg[WIDTH-1]!=reg[WIDTH-2] then ovf<=1 (sticky).
  - reg<=reg<<1, LSB filled with 0. cnt<=cnt-1.
  - When cnt==1 on that edge, next state is DONE.
- DONE:
  - out_valid=1, xout=reg, ovf held.
  - xout and ovf are stable while out_ready=0.
  - An edge with out_ready=1 returns the block to IDLE and clears out_valid.
  - No input is accepted in DONE, so a new accept is possible at the earliest one edge after the result is taken.
- Latency: out_valid rises after shamt+1 rising edges, counting the accepting edge as edge 1. Throughput is one word per shamt+2 cycles when out_ready=1.
- Overflow check: evaluated before each individual shift, so ovf=1 if and only if xin*2^shamt lies outside the signed WIDTH-bit range.
- Inputs are ignored whenever in_ready=0; in_valid held high during SHIFT/DONE has no effect.
- Never both in_ready=1 and out_valid=1 in the same cycle.

Optional Feature:
- Macro: SHIFTER_LEFT_SAT_EN.
- When defined:
  - On the first overflowing shift, reg<=sign ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}. For WIDTH=16 this is 0x8000 or 0x7FFF.
  - Subsequent shifts in the same operation hold reg unchanged.
  - cnt keeps decrementing, so latency is unchanged.
- When undefined: results wrap (plain truncated shift) and ovf is still reported.

Test Plan:
- Reset, then xin=0x0003, shamt=4, out_ready=1 -> out_valid rises after 5 edges; xout=0x0030, ovf=0; in_ready back to 1 one edge after the result is taken.
- xin=0xFFFF, shamt=15 -> xout=0x8000, ovf=0, 16-edge latency. shamt=0 with xin=0x1234 -> xout=0x1234 after 1 edge.
- xin=0x4000, shamt=1 -> ovf=1. Without SHIFTER_LEFT_SAT_EN: xout=0x8000. With it: xout=0x7FFF.
- xin=0xA000, shamt=3 -> ovf=1. Wrap build: xout=0x0000. SAT build: xout=0x8000.
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 and new data -> xout and ovf are stable, in_ready=0, new data is not captured. Releasing out_ready gives exactly one transfer.
- Assert rst_n=0 asynchronously mid-SHIFT (xin=0x0001, shamt=8, after 3 edges) -> outputs take reset values immediately. Restart with xin=0x0001, shamt=2 -> xout=0x0004.
